// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage operand bypass bus: decoded register fields in, mux selects and stall out.
// The controller takes the slave side; the pipeline decode stage takes the master side.
interface fwd_hazard_ctrl_if #(
  parameter int RN_W = 5
);
  logic [RN_W-1:0] id_rs;
  logic [RN_W-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_wreg;
  logic            id_m2reg;
  logic [RN_W-1:0] id_rn;
  logic [1:0]      fwda;
  logic [1:0]      fwdb;
  logic            wpcir;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn,
    input  fwda, fwdb, wpcir
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_rn,
    output fwda, fwdb, wpcir
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the ID-stage operand bypass.
// Optional stall counter output enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_ctrl #(
  parameter int RN_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  fwd_hazard_ctrl_if.slave    bus
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  // Shadow copy of the destination info held by the EX and MEM stages.
  logic            ex_wreg_reg;
  logic            ex_m2reg_reg;
  logic [RN_W-1:0] ex_rn_reg;
  logic            mem_wreg_reg;
  logic            mem_m2reg_reg;
  logic [RN_W-1:0] mem_rn_reg;

  logic            ex_wreg_next;
  logic            ex_m2reg_next;
  logic [RN_W-1:0] ex_rn_next;

  logic            ex_valid;
  logic            mem_valid;
  logic [RN_W-1:0] src [2];
  logic [1:0]      use_src;
  logic [1:0]      load_use;
  logic [3:0]      sel_all;
  logic            stall;

  // r0 is hard-wired zero, so a write to it never produces a forwardable value.
  assign ex_valid  = ex_wreg_reg  & (ex_rn_reg  != '0);
  assign mem_valid = mem_wreg_reg & (mem_rn_reg != '0);

  assign src[0]  = bus.id_rs;
  assign src[1]  = bus.id_rt;
  assign use_src = {bus.id_use_rt, bus.id_use_rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic       ex_hit;
      logic       mem_hit;
      logic [1:0] sel;

      assign ex_hit  = ex_valid  & (ex_rn_reg  == src[gi]);
      assign mem_hit = mem_valid & (mem_rn_reg == src[gi]);

      // Only a genuinely read operand can stall; selects ignore the use flags.
      assign load_use[gi] = ex_hit & ex_m2reg_reg & use_src[gi];

      // A load still in EX must shadow any older MEM match: its data is not
      // ready yet, and the stall resolves the operand next cycle.
      always_comb begin
        sel = 2'b00;
        if (ex_hit) begin
          sel = ex_m2reg_reg ? 2'b00 : 2'b01;
        end else if (mem_hit) begin
          sel = mem_m2reg_reg ? 2'b11 : 2'b10;
        end
      end

      assign sel_all[gi*2 +: 2] = sel;
    end
  endgenerate

  assign stall     = |load_use;
  assign bus.wpcir = ~stall;
  assign bus.fwda  = sel_all[1:0];
  assign bus.fwdb  = sel_all[3:2];

  // A stall turns the instruction entering EX into a bubble.
  always_comb begin
    ex_wreg_next  = bus.id_wreg;
    ex_m2reg_next = bus.id_m2reg;
    ex_rn_next    = bus.id_rn;
    if (stall) begin
      ex_wreg_next  = 1'b0;
      ex_m2reg_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_wreg_reg   <= 1'b0;
      ex_m2reg_reg  <= 1'b0;
      ex_rn_reg     <= '0;
      mem_wreg_reg  <= 1'b0;
      mem_m2reg_reg <= 1'b0;
      mem_rn_reg    <= '0;
    end else begin
      ex_wreg_reg   <= ex_wreg_next;
      ex_m2reg_reg  <= ex_m2reg_next;
      ex_rn_reg     <= ex_rn_next;
      mem_wreg_reg  <= ex_wreg_reg;
      mem_m2reg_reg <= ex_m2reg_reg;
      mem_rn_reg    <= ex_rn_reg;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed vector table, reset-in-stall
// sequence, and randomized traffic against a stage-list reference model.
module tb_fwd_hazard_ctrl;
  localparam int RN_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.RN_W(RN_W)) bus ();

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fwd_hazard_ctrl #(.RN_W(RN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       wp;
  } vec_t;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } stage_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: list of in-flight writers, index 0 = EX, 1 = MEM.
  stage_t      m_st [2];
  int unsigned m_cnt;

  function automatic vec_t mk(input int rs, input int rt, input bit urs, input bit urt,
                              input bit wreg, input bit m2, input int rn,
                              input int fa, input int fb, input bit wp);
    vec_t v;
    v.rs = 5'(rs);  v.rt = 5'(rt);
    v.use_rs = urs; v.use_rt = urt;
    v.wreg = wreg;  v.m2reg = m2;  v.rn = 5'(rn);
    v.fa = 2'(fa);  v.fb = 2'(fb); v.wp = wp;
    return v;
  endfunction

  // Youngest in-flight writer of src decides the source; a load in EX is not
  // ready, so the operand comes from the register file (and the pipe stalls).
  function automatic logic [1:0] m_sel(input logic [4:0] src);
    for (int s = 0; s < 2; s++) begin
      if (m_st[s].wreg && m_st[s].rn != 5'd0 && m_st[s].rn == src) begin
        if (s == 0) return m_st[s].m2reg ? 2'b00 : 2'b01;
        return m_st[s].m2reg ? 2'b11 : 2'b10;
      end
    end
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit pending_load;
    pending_load = m_st[0].wreg && m_st[0].m2reg && m_st[0].rn != 5'd0;
    return pending_load && ((bus.id_use_rs && bus.id_rs == m_st[0].rn) ||
                            (bus.id_use_rt && bus.id_rt == m_st[0].rn));
  endfunction

  task automatic m_reset();
    m_st[0] = '0;
    m_st[1] = '0;
    m_cnt   = 0;
  endtask

  task automatic m_step();
    stage_t nxt;
    bit     st;
    st = m_stall();
    nxt.wreg  = st ? 1'b0 : bus.id_wreg;
    nxt.m2reg = st ? 1'b0 : bus.id_m2reg;
    nxt.rn    = bus.id_rn;
    m_st[1] = m_st[0];
    m_st[0] = nxt;
    if (st && m_cnt != 32'hFFFF_FFFF) m_cnt++;
  endtask

  task automatic drive(input vec_t v);
    bus.id_rs     = v.rs;
    bus.id_rt     = v.rt;
    bus.id_use_rs = v.use_rs;
    bus.id_use_rt = v.use_rt;
    bus.id_wreg   = v.wreg;
    bus.id_m2reg  = v.m2reg;
    bus.id_rn     = v.rn;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                          input logic wp);
    chk({tag, ".fwda"},  32'(bus.fwda),  32'(fa));
    chk({tag, ".fwdb"},  32'(bus.fwdb),  32'(fb));
    chk({tag, ".wpcir"}, 32'(bus.wpcir), 32'(wp));
  endtask

  vec_t tbl [17];
  vec_t idle;
  vec_t rv;
  bit   prev_stall;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Directed program: EX/MEM forwarding, load spacing, load-use, priority, r0.
    tbl[0]  = mk(1, 2, 1, 1, 1, 0, 3,   0, 0, 1);  // add r3
    tbl[1]  = mk(3, 4, 1, 1, 0, 0, 0,   1, 0, 1);  // reads r3 from EX
    tbl[2]  = mk(0, 0, 0, 0, 1, 0, 5,   0, 0, 1);  // add r5
    tbl[3]  = mk(1, 2, 1, 1, 0, 0, 0,   0, 0, 1);  // unrelated
    tbl[4]  = mk(1, 5, 1, 1, 0, 0, 0,   0, 2, 1);  // rt=r5 from MEM ALU
    tbl[5]  = mk(2, 0, 1, 0, 1, 1, 6,   0, 0, 1);  // lw r6
    tbl[6]  = mk(1, 2, 1, 1, 0, 0, 0,   0, 0, 1);  // unrelated
    tbl[7]  = mk(6, 0, 1, 0, 0, 0, 0,   3, 0, 1);  // rs=r6 from MEM load
    tbl[8]  = mk(1, 0, 1, 0, 1, 1, 7,   0, 0, 1);  // lw r7
    tbl[9]  = mk(7, 3, 1, 1, 1, 0, 10,  0, 0, 0);  // load-use: stall
    tbl[10] = mk(7, 3, 1, 1, 1, 0, 10,  3, 0, 1);  // held, resolves from MEM
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 9,   0, 0, 1);  // add r9
    tbl[12] = mk(9, 10, 1, 1, 1, 0, 9,  1, 2, 1);  // sub r9; r10 from MEM
    tbl[13] = mk(9, 9, 1, 1, 1, 0, 0,   1, 1, 1);  // EX r9 beats MEM r9; writes r0
    tbl[14] = mk(0, 0, 1, 1, 0, 0, 0,   0, 0, 1);  // r0 never forwarded
    tbl[15] = mk(0, 0, 0, 0, 1, 1, 0,   0, 0, 1);  // lw r0
    tbl[16] = mk(0, 0, 1, 0, 0, 0, 0,   0, 0, 1);  // r0 after lw r0: no stall

    drive(idle);
    m_reset();
    #1 rst = 1'b1;
    #1 chk_outs("reset", 2'b00, 2'b00, 1'b1);
`ifdef FWD_STALL_CNT_EN
    chk("reset.stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      $display("vec %0d rs=%0d rt=%0d wreg=%0b m2reg=%0b rn=%0d -> fwda=%b fwdb=%b wpcir=%b",
               i, tbl[i].rs, tbl[i].rt, tbl[i].wreg, tbl[i].m2reg, tbl[i].rn,
               bus.fwda, bus.fwdb, bus.wpcir);
      chk_outs($sformatf("tbl%0d", i), tbl[i].fa, tbl[i].fb, tbl[i].wp);
      m_step();
    end
`ifdef FWD_STALL_CNT_EN
    chk("tbl.stall_cnt", stall_cnt, 32'd1);
`endif

    // Reset asserted while a load-use stall is in progress.
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 1, 1, 8, 0, 0, 1));   // lw r8
    #1 m_step();
    @(negedge clk);
    drive(mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 0));   // reads r8
    #1 chk("rst_mid.pre_stall", 32'(bus.wpcir), 32'd0);
    #1 rst = 1'b1;
    #1 chk_outs("rst_mid", 2'b00, 2'b00, 1'b1);
    $display("reset during stall -> fwda=%b fwdb=%b wpcir=%b", bus.fwda, bus.fwdb, bus.wpcir);
`ifdef FWD_STALL_CNT_EN
    chk("rst_mid.stall_cnt", stall_cnt, 32'd0);
`endif
    m_reset();
    @(negedge clk);
    drive(idle);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_outs($sformatf("post_rst%0d", i), 2'b00, 2'b00, 1'b1);
      $display("idle %0d after reset -> fwda=%b fwdb=%b wpcir=%b", i, bus.fwda, bus.fwdb, bus.wpcir);
      m_step();
      @(negedge clk);
    end

    // Random traffic over a small register range so dependencies are frequent.
    prev_stall = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!prev_stall) begin
        rv = mk($urandom_range(0, 7), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                $urandom_range(0, 7), 0, 0, 1);
        drive(rv);
      end
      #1;
      chk_outs($sformatf("rnd%0d", n), m_sel(bus.id_rs), m_sel(bus.id_rt), ~m_stall());
`ifdef FWD_STALL_CNT_EN
      chk($sformatf("rnd%0d.stall_cnt", n), stall_cnt, m_cnt);
`endif
      $display("rnd %0d rs=%0d rt=%0d use=%0b%0b wreg=%0b m2reg=%0b rn=%0d -> fwda=%b fwdb=%b wpcir=%b",
               n, bus.id_rs, bus.id_rt, bus.id_use_rs, bus.id_use_rt, bus.id_wreg,
               bus.id_m2reg, bus.id_rn, bus.fwda, bus.fwdb, bus.wpcir);
      prev_stall = m_stall();
      m_step();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the ID-stage operand bypass of the pipelined MIPS CPU.
- Keeps its own shadow copy of the destination info for the EX and MEM stages.
- Drives the 2-bit selects of the two 32-bit 4:1 operand muxes (A and B).
- Detects load-use hazards and stalls PC and IF/ID for one cycle, inserting a bubble into EX.
- WB-stage hazards are out of scope: the register file writes on the falling edge.

Parameters:
- RN_W, 5, register-number width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- id_rs  input  RN_W  rs field of the instruction in ID.
- id_rt  input  RN_W  rt field of the instruction in ID.
- id_use_rs  input  1  ID instruction reads rs.
- id_use_rt  input  1  ID instruction reads rt.
- id_wreg  input  1  ID instruction writes the register file.
- id_m2reg  input  1  ID instruction is a load (result comes from memory).
- id_rn  input  RN_W  destination register of the ID instruction.
- fwda  output  2  select for operand-A mux: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- fwdb  output  2  select for operand-B mux, same encoding as fwda.
- wpcir  output  1  PC and IF/ID write enable; 0 = stall.

Behaviour:
- Shadow registers: ex_wreg, ex_m2reg, ex_rn, mem_wreg, mem_m2reg, mem_rn. Reset asynchronously to 0.
- Each rising edge, when not stalled (wpcir=1): ex_* <= id_*.
- Each rising edge, when stalled (wpcir=0): ex_wreg <= 0 and ex_m2reg <= 0 (bubble); ex_rn <= id_rn.
- Each rising edge, regardless of stall: mem_* <= ex_*.
- Hazard condition, combinational: stall = ex_wreg & ex_m2reg & (ex_rn != 0) & ((id_use_rs & ex_rn == id_rs) | (id_use_rt & ex_rn == id_rt)).
- wpcir = ~stall.
- fwda, combinational, evaluated in priority order (first match wins):
  1. ex_wreg & ~ex_m2reg & ex_rn != 0 & ex_rn == id_rs -> 01.
  2. ex_wreg & ex_m2reg & ex_rn == id_rs -> 00. The stall covers this case; EX must not be skipped in favour of an older MEM value.
  3. mem_wreg & mem_rn != 0 & mem_rn == id_rs -> 11 if mem_m2reg, else 10.
  4. Otherwise -> 00.
- fwdb: same rules using id_rt.
- Forwarding is not gated by id_use_*; the mux output is ignored when the operand is unused.
- Register 0 is never forwarded and never causes a stall.
- EX has priority over MEM when both match the same register (the youngest value wins).
- Stall length is exactly one cycle for a load-use pair. Next cycle:
  - EX holds the bubble.
  - MEM holds the load.
  - Selects resolve to 11 for the dependent operand.
  - wpcir returns to 1.
- Reset values (any time, including mid-stall): all shadow registers 0, so fwda=00, fwdb=00, wpcir=1.
- Latency: outputs are combinational from the ID inputs and the registered shadows; no added pipeline delay.

Optional Feature:
- Macro: FWD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt, 32 bits.
  - Increments on each rising edge where wpcir=0.
  - Saturates at 32'hFFFFFFFF and does not wrap.
  - Resets asynchronously to 0.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-stall (ex load to r8, ID reads r8) -> immediately fwda=00, fwdb=00, wpcir=1; after release with ID idle, outputs stay unchanged.
- EX forward: cycle n ID = add r3 (wreg=1, m2reg=0, rn=3); cycle n+1 ID = use rs=3, rt=4 -> fwda=01, fwdb=00, wpcir=1.
- MEM forward, ALU result: add r5, then one unrelated instruction, then ID rt=5 -> fwdb=10.
- MEM forward, load with one instruction between: lw r6, then an unrelated instruction, then ID rs=6 -> fwda=11, no stall.
- Load-use: lw r7 in ID, then ID rs=7 with use_rs=1 -> wpcir=0 for exactly one cycle; next cycle fwda=11, wpcir=1.
  - With FWD_STALL_CNT_EN defined: stall_cnt 0 -> 1.
- Priority and r0:
  - add r9, then sub r9, then ID rs=9 -> fwda=01 (EX wins).
  - Writer with rn=0 followed by ID rs=0 -> fwda=00, no stall.
